// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: default widths, reset vector and the
// sequential PC step used by fetch, branch and PC logic.
package cpu_pkg;

  localparam int          DEF_INST_W   = 32;
  localparam int          DEF_ADDR_W   = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int          PC_INC       = 4;

endpackage

// File: rtl/fetch_ring_buf.sv
// Power-of-two ring buffer holding fetched {instruction, pc} pairs, with
// push/pop, occupancy count and a synchronous flush.
module fetch_ring_buf
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int INST_W = DEF_INST_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [INST_W-1:0]            push_inst,
  input  logic [ADDR_W-1:0]            push_pc,
  input  logic                         pop,
  output logic [INST_W-1:0]            head_inst,
  output logic [ADDR_W-1:0]            head_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  assign head_inst = inst_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

  // Storage is zeroed only on reset so the head reads 0 out of reset;
  // a flush just rewinds the pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        assert (count != FULL);
        inst_mem[wr_ptr] <= push_inst;
        pc_mem[wr_ptr]   <= push_pc;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues credit-limited sequential ROM reads
// and buffers the returned words; redirects flush and drop in-flight data.
module inst_fetch_queue
  import cpu_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                INST_W   = DEF_INST_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_next_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [CW:0]       credit_used;
  logic              pop;
  logic              push;
  logic              issue;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = inflight && !redirect_valid;

  // Slots already claimed (queued + in flight), less the one leaving now.
  // pop implies count >= 1, so this never underflows.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue       = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));

  assign rom_ce      = issue;
  assign rom_addr    = fetch_pc;
  assign out_next_pc = out_pc + ADDR_W'(PC_INC);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc;
      inflight    <= 1'b0;
      inflight_pc <= fetch_pc;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
      end
      inflight    <= issue;
      inflight_pc <= fetch_pc;
    end
  end

  fetch_ring_buf #(
    .DEPTH  (DEPTH),
    .INST_W (INST_W),
    .ADDR_W (ADDR_W)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (push),
    .push_inst (rom_inst),
    .push_pc   (inflight_pc),
    .pop       (pop),
    .head_inst (out_inst),
    .head_pc   (out_pc),
    .count     (count)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: DEPTH=4 and DEPTH=2 instances share stimulus and
// are compared each cycle against a queue-based reference model.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        out_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        rom_ce      [2];
  logic [31:0] rom_addr    [2];
  logic [31:0] rom_inst    [2];
  logic        out_valid   [2];
  logic [31:0] out_inst    [2];
  logic [31:0] out_pc      [2];
  logic [31:0] out_next_pc [2];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          depth_of [2] = '{4, 2};
  logic [31:0] m_fetch  [2];
  bit          m_infl   [2];
  logic [31:0] m_infl_pc[2];
  logic [31:0] q_pc     [2][$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ROM: word for the address one cycle later, junk when not enabled.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      rom_inst[k] <= rom_ce[k] ? rom_fn(rom_addr[k]) : $urandom;
  end

  inst_fetch_queue #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .rom_ce(rom_ce[0]), .rom_addr(rom_addr[0]),
    .rom_inst(rom_inst[0]), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_inst(out_inst[0]),
    .out_pc(out_pc[0]), .out_next_pc(out_next_pc[0])
  );

  inst_fetch_queue #(.DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .rom_ce(rom_ce[1]), .rom_addr(rom_addr[1]),
    .rom_inst(rom_inst[1]), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_inst(out_inst[1]),
    .out_pc(out_pc[1]), .out_next_pc(out_next_pc[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=0x%08h expected=0x%08h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset(input int k, input logic [31:0] pc);
    q_pc[k].delete();
    m_fetch[k]   = pc;
    m_infl[k]    = 1'b0;
    m_infl_pc[k] = '0;
  endtask

  // One clock: drive inputs, compare against the model, advance the model.
  task automatic step(input bit r, input bit rdy, input bit rv, input logic [31:0] rpc);
    rst            = r;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    for (int k = 0; k < 2; k++) begin
      bit ev;
      bit pop;
      bit iss;
      int occ;
      string s;
      s   = (k == 0) ? "d4" : "d2";
      ev  = (q_pc[k].size() != 0);
      pop = ev && rdy;
      occ = q_pc[k].size() + int'(m_infl[k]) - int'(pop);
      iss = !r && !rv && (occ < depth_of[k]);
      check({s, "_out_valid"}, 32'(out_valid[k]), 32'(ev));
      check({s, "_rom_ce"}, 32'(rom_ce[k]), 32'(iss));
      check({s, "_rom_addr"}, rom_addr[k], m_fetch[k]);
      if (ev) begin
        check({s, "_out_pc"}, out_pc[k], q_pc[k][0]);
        check({s, "_out_inst"}, out_inst[k], rom_fn(q_pc[k][0]));
        check({s, "_out_next_pc"}, out_next_pc[k], q_pc[k][0] + 32'd4);
      end
      if (r) begin
        model_reset(k, 32'h0);
      end else if (rv) begin
        model_reset(k, rpc);
      end else begin
        if (pop) void'(q_pc[k].pop_front());
        if (m_infl[k]) q_pc[k].push_back(m_infl_pc[k]);
        m_infl[k]    = iss;
        m_infl_pc[k] = m_fetch[k];
        if (iss) m_fetch[k] = m_fetch[k] + 32'd4;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) model_reset(k, 32'h0);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_out_valid", 32'(out_valid[k]), 32'h0);
      check("rst_rom_ce", 32'(rom_ce[k]), 32'h0);
      check("rst_rom_addr", rom_addr[k], 32'h0);
      check("rst_out_inst", out_inst[k], 32'h0);
      check("rst_out_pc", out_pc[k], 32'h0);
      check("rst_out_next_pc", out_next_pc[k], 32'h4);
    end
    step(1, 0, 0, '0);

    // streaming, then stall and release
    repeat (12) step(0, 1, 0, '0);
    repeat (10) step(0, 0, 0, '0);
    repeat (8)  step(0, 1, 0, '0);

    // redirect with a partly filled queue and a word in flight
    repeat (3) step(0, 0, 0, '0);
    step(0, 0, 1, 32'h100);
    repeat (6) step(0, 1, 0, '0);

    // back-to-back redirects
    step(0, 1, 1, 32'h200);
    step(0, 1, 1, 32'h300);
    repeat (6) step(0, 1, 0, '0);

    // redirect coinciding with a pop
    step(0, 1, 1, 32'h400);
    repeat (3) step(0, 0, 0, '0);
    step(0, 1, 1, 32'h500);
    repeat (5) step(0, 1, 0, '0);

    // PC wrap at the top of the address space
    step(0, 1, 1, 32'hFFFF_FFF0);
    repeat (10) step(0, 1, 0, '0);
    step(0, 0, 1, 32'hFFFF_FFF8);
    repeat (4) step(0, 0, 0, '0);
    repeat (6) step(0, 1, 0, '0);

    // reset mid-operation
    step(1, 1, 0, '0);
    repeat (6) step(0, 1, 0, '0);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      bit          rdy;
      bit          rv;
      logic [31:0] tgt;
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      step(($urandom_range(0, 199) == 0), rdy, rv, tgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
